pc_predict_gen: RTL and testbench
=================================

# pc_predict_gen

Parametrised program-counter generator for the RV32I fetch stage, adding a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It produces the fetch PC each cycle, predicts taken branches and jumps from the BTB, and accepts redirects and training updates from the execute stage. It sits at the head of IF and feeds the instruction memory address and the IF/ID prediction fields.

## Interface
Parameters:
- XLEN, 32, address/PC width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; load-use hazard.
- redirect_valid  in  1  execute-stage redirect: mispredict, or jalr target.
- redirect_pc  in  XLEN  redirect target.
- upd_valid  in  1  execute stage resolved a branch or jump this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  resolved direction; 1 for jal/jalr.
- upd_target  in  XLEN  resolved target.
- pc  out  XLEN  current fetch PC, registered.
- pred_taken  out  1  BTB predicts taken for `pc`.
- pred_target  out  XLEN  predicted target; valid only when pred_taken=1.

## Operation
- BTB index = pc[IDX+1:2] with IDX = log2(BTB_ENTRIES). Tag = pc[XLEN-1:IDX+2].
- Each BTB entry holds: valid, tag, target, ctr[1:0].
- Lookup is combinational on `pc`. hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = entry target.
- Next-PC priority, highest first:
  1. redirect_valid: next PC is redirect_pc.
  2. stall: PC holds.
  3. pred_taken: next PC is pred_target.
  4. Otherwise: next PC is pc+4, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0.
- Update, applied on upd_valid at the clock edge. Updates are independent of stall and redirect.
  - Hit on upd_pc, upd_taken=1: ctr increments, saturating at 2'b11; target is overwritten with upd_target.
  - Hit, upd_taken=0: ctr decrements, saturating at 2'b00; target is unchanged; valid stays set.
  - Miss, upd_taken=1: the entry is allocated or replaced. valid=1, new tag, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss, upd_taken=0: no change.
- upd_pc[1:0] and pc[1:0] are ignored for indexing and tags.
- Mid-operation reset: pc is forced to RESET_VECTOR and all valid bits clear immediately, regardless of any in-flight update.

## Timing
- Reset values:
  - pc = RESET_VECTOR.
  - All BTB valid = 0, hence pred_taken = 0.
  - pred_target reads as the don't-care entry target.
- pc changes one cycle after the driving condition. After redirect_valid in cycle n, pc equals redirect_pc in cycle n+1.
- Prediction has zero-cycle latency: pred_taken and pred_target correspond to `pc` in the same cycle.
- A BTB write in cycle n is visible to lookup from cycle n+1. A same-cycle lookup of the same index sees the old contents; there is no write-through.
- Simultaneous events:
  - redirect_valid with stall: redirect wins.
  - upd_valid with redirect_valid: both take effect.
  - upd_valid with stall: the update applies.
- Redirect generation on mispredict is the execute stage's responsibility; this block never self-corrects.

## Configuration
- PC_PREDICT_BTB_EN defined: BTB and prediction are as above.
- PC_PREDICT_BTB_EN undefined:
  - No BTB storage is built.
  - pred_taken is tied to 0 and pred_target to 0.
  - upd_* inputs are ignored.
  - Next PC = redirect_pc, else hold on stall, else pc+4.

## Structure
- Package pc_predict_pkg holds:
  - btb_entry_t struct: valid, tag, target, ctr.
  - ctr_t and its constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Function ctr_next(ctr, taken) implementing saturating update.
- Sub-module pc_btb: storage, lookup port, update port, parameterised by XLEN/BTB_ENTRIES.
- The top level holds the PC register and next-PC mux.

## Test plan
- Reset mid-run:
  - Stimulus: assert rst with pc=0x40 and upd_valid high.
  - Required: pc=RESET_VECTOR immediately; after release, pc steps 0,4,8; pred_taken=0.
- Allocation:
  - Stimulus: upd_valid, upd_pc=0x10, upd_taken=1, upd_target=0x80.
  - Required: when pc next reaches 0x10, pred_taken=1, pred_target=0x80, and the following pc=0x80.
- Counter saturation:
  - Stimulus: after allocation, apply three not-taken updates at 0x10.
  - Required: ctr goes 10→01→00→00; pred_taken=0 at pc 0x10; the following pc=0x14.
- Alias replacement, with BTB_ENTRIES=16:
  - Stimulus: a taken update at 0x10, then a taken update at 0x50 (same index, different tag), target 0x200.
  - Required: pc=0x10 misses; pc=0x50 predicts 0x200.
- Priority:
  - Stimulus: stall=1, redirect_valid=1, redirect_pc=0x300, pred_taken=1 at the same time.
  - Required: next pc=0x300. With stall=1 alone, pc holds for 3 cycles.
- Wrap and macro:
  - Stimulus: pc=0xFFFF_FFFC with no prediction.
  - Required: next pc=0.
  - With PC_PREDICT_BTB_EN undefined, the allocation scenario yields pred_taken=0 and sequential pc.

Source files
------------

// File: rtl/pc_predict_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_predict_pkg
// Brief    : Shared BTB entry type and 2-bit direction counter helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pc_predict_pkg;

  // Entry fields are sized for the RV32I address space.
  localparam int C_BTB_FIELD_W = 32;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic                     valid;
    logic [C_BTB_FIELD_W-1:0] tag;
    logic [C_BTB_FIELD_W-1:0] target;
    ctr_t                     ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_btb.sv
`default_nettype none
// ============================================================================
// Module   : pc_btb
// Brief    : Direct-mapped branch target buffer, combinational lookup port
//            and single clocked training port.
// Revision : 1.0 - initial release
// ============================================================================
module pc_btb
  import pc_predict_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t r_mem [BTB_ENTRIES];

  logic [IDX-1:0]           w_rd_idx;
  logic [IDX-1:0]           w_upd_idx;
  logic [C_BTB_FIELD_W-1:0] w_rd_tag;
  logic [C_BTB_FIELD_W-1:0] w_upd_tag;
  btb_entry_t               w_rd;
  btb_entry_t               w_upd_old;
  logic                     w_rd_hit;
  logic                     w_upd_hit;
  logic                     w_unused_addr_bits;

  assign w_rd_idx  = lookup_pc[IDX+1:2];
  assign w_upd_idx = upd_pc[IDX+1:2];
  assign w_rd_tag  = C_BTB_FIELD_W'(lookup_pc[XLEN-1:IDX+2]);
  assign w_upd_tag = C_BTB_FIELD_W'(upd_pc[XLEN-1:IDX+2]);

  // Byte-offset bits never take part in indexing or tagging.
  assign w_unused_addr_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign w_rd      = r_mem[w_rd_idx];
  assign w_upd_old = r_mem[w_upd_idx];
  assign w_rd_hit  = w_rd.valid && (w_rd.tag == w_rd_tag);
  assign w_upd_hit = w_upd_old.valid && (w_upd_old.tag == w_upd_tag);

  assign pred_taken  = w_rd_hit && w_rd.ctr[1];
  assign pred_target = w_rd.target[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        r_mem[w_upd_idx].ctr <= ctr_next(w_upd_old.ctr, upd_taken);
        if (upd_taken) begin
          r_mem[w_upd_idx].target <= C_BTB_FIELD_W'(upd_target);
        end
      end else if (upd_taken) begin
        r_mem[w_upd_idx] <= '{valid:  1'b1,
                               tag:    w_upd_tag,
                               target: C_BTB_FIELD_W'(upd_target),
                               ctr:    CTR_WT};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_predict_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_predict_gen
// Brief    : RV32I fetch PC generator with optional BTB prediction; the BTB is
//            built only when PC_PREDICT_BTB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pc_predict_gen
  import pc_predict_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

`ifdef PC_PREDICT_BTB_EN
  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (r_pc),
    .pred_taken  (w_pred_taken),
    .pred_target (w_pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );
`else
  logic w_unused_upd;

  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
  assign w_unused_upd  = ^{upd_valid, upd_pc, upd_taken, upd_target};
`endif

  // Redirect beats stall, and stall beats a predicted-taken target.
  always_comb begin
    w_next_pc = r_pc + XLEN'(4);
    if (redirect_valid) begin
      w_next_pc = redirect_pc;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc          = r_pc;
  assign pred_taken  = w_pred_taken;
  assign pred_target = w_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_pc_predict_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_predict_gen
// Brief    : Directed self-checking bench for pc_predict_gen; expectations
//            follow whichever build (BTB enabled or not) is compiled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_predict_gen;

`ifdef PC_PREDICT_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int checks = 0;
  int errors = 0;

  pc_predict_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .BTB_ENTRIES  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    checks++;
    if (pc !== exp) begin
      errors++;
      $display("FAIL %s: pc=%h expected %h", name, pc, exp);
    end
  endtask

  task automatic chk_pred(input string name, input logic exp_t, input logic [31:0] exp_tgt);
    checks++;
    if (pred_taken !== exp_t || (exp_t && pred_target !== exp_tgt)) begin
      errors++;
      $display("FAIL %s: pred_taken=%b pred_target=%h expected %b/%h",
               name, pred_taken, pred_target, exp_t, exp_tgt);
    end
  endtask

  task automatic jump_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    chk_pc("reset_pc", 32'h0);
    chk_pred("reset_pred", 1'b0, 32'h0);
    rst = 1'b0;
    chk_pc("after_release_0", 32'h0);
    tick();
    chk_pc("after_release_4", 32'h4);
    tick();
    chk_pc("after_release_8", 32'h8);
  endtask

  task automatic test_allocation();
    // pc = 0x8: train 0x10 -> 0x80 one cycle ahead of reaching it
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h80;
    tick();
    upd_valid = 1'b0;
    chk_pc("alloc_pc_c", 32'hC);
    chk_pred("alloc_miss_at_c", 1'b0, 32'h0);
    tick();
    chk_pc("alloc_pc_10", 32'h10);
    chk_pred("alloc_pred_at_10", BTB_ON, 32'h80);
    if (!BTB_ON) begin
      checks++;
      if (pred_target !== 32'h0) begin
        errors++;
        $display("FAIL alloc_target_tied: pred_target=%h expected 0", pred_target);
      end
    end
    tick();
    chk_pc("alloc_follow", BTB_ON ? 32'h80 : 32'h14);
  endtask

  task automatic test_saturation();
    // redirect and update together, then two more not-taken updates under stall
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0;
    tick();
    redirect_valid = 1'b0;
    chk_pc("sat_redirect_with_upd", 32'h100);
    stall = 1'b1;
    repeat (2) tick();
    upd_valid = 1'b0;
    stall = 1'b0;
    chk_pc("sat_stall_hold", 32'h100);
    jump_to(32'h10);
    chk_pred("sat_strong_nt", 1'b0, 32'h0);
    tick();
    chk_pc("sat_follow_14", 32'h14);
    // 00 -> 01: still not taken; 01 -> 10 becomes taken
    stall = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h80;
    tick();
    upd_valid = 1'b0;
    stall = 1'b0;
    jump_to(32'h10);
    chk_pred("sat_weak_nt", 1'b0, 32'h0);
    stall = 1'b1;
    upd_valid = 1'b1;
    #1;
    chk_pred("sat_no_write_through", 1'b0, 32'h0);
    tick();
    upd_valid = 1'b0;
    chk_pc("sat_stall_over_pred", 32'h10);
    chk_pred("sat_weak_taken", BTB_ON, 32'h80);
    stall = 1'b0;
  endtask

  task automatic test_alias();
    stall = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b1; upd_target = 32'h200;
    tick();
    upd_valid = 1'b0;
    stall = 1'b0;
    jump_to(32'h10);
    chk_pred("alias_old_tag_miss", 1'b0, 32'h0);
    tick();
    chk_pc("alias_seq_after_10", 32'h14);
    jump_to(32'h53);
    chk_pred("alias_new_tag_hit", BTB_ON, 32'h200);
    tick();
    chk_pc("alias_follow", BTB_ON ? 32'h200 : 32'h57);
  endtask

  task automatic test_priority();
    jump_to(32'h50);
    chk_pred("prio_pred_present", BTB_ON, 32'h200);
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk_pc("prio_redirect_wins", 32'h300);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pc("prio_stall_hold", 32'h300);
    end
    stall = 1'b0;
    tick();
    chk_pc("prio_resume", 32'h304);
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFF8);
    tick();
    chk_pc("wrap_fffc", 32'hFFFF_FFFC);
    chk_pred("wrap_no_pred", 1'b0, 32'h0);
    tick();
    chk_pc("wrap_zero", 32'h0);
  endtask

  task automatic test_reset_mid();
    jump_to(32'h40);
    chk_pc("midrst_pc_40", 32'h40);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h90;
    #3;
    rst = 1'b1;
    #1;
    chk_pc("midrst_async_pc", 32'h0);
    chk_pred("midrst_pred_clear", 1'b0, 32'h0);
    tick();
    upd_valid = 1'b0;
    rst = 1'b0;
    chk_pc("midrst_step0", 32'h0);
    tick();
    chk_pc("midrst_step4", 32'h4);
    tick();
    chk_pc("midrst_step8", 32'h8);
    jump_to(32'h40);
    chk_pred("midrst_update_dropped", 1'b0, 32'h0);
    jump_to(32'h50);
    chk_pred("midrst_btb_cleared", 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_allocation();
    test_saturation();
    test_alias();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
